// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Write side of the 18-bit x 1024 instruction memory. Receives a framed byte
// stream over valid/ready, assembles 18-bit words, writes them at sequential
// addresses from 0, verifies the XOR checksum, then pulses the core start.
// The core is held (cpu_hold) for the whole load.
//
// Frame: LEN_LO, LEN_HI, N x {B0, B1, B2}, CHK
//   LEN = N-1 (10 bits), word = {B2[1:0], B1, B0}, CHK = XOR of all prior bytes.
//   Upper six bits of LEN_HI and every B2 must be zero.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   load          : one-cycle load request, honoured only in IDLE/DONE/ERR
//   in_data[7:0]  : stream byte
//   in_valid      : stream byte valid
//   in_ready      : loader accepts a byte this cycle
//   mem_we        : instruction memory write strobe (one cycle per word)
//   mem_addr[9:0] : write address (current word index)
//   mem_wdata[17:0]: assembled instruction word
//   cpu_hold      : core must not fetch while high
//   cpu_start     : one-cycle start pulse after a good load
//   done          : last load completed with a good checksum
//   error         : last load aborted on a format or checksum fault
// ---------------------------------------------------------------------------
module program_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [17:0] mem_wdata,
    output logic        cpu_hold,
    output logic        cpu_start,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_B0     = 4'd3,
        S_B1     = 4'd4,
        S_B2     = 4'd5,
        S_WRITE  = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  len_m1;     // N-1 as received
    logic [9:0]  word_idx;   // index of the word being assembled / written
    logic [7:0]  run_xor;    // XOR of every accepted byte so far
    logic [17:0] word;       // word under assembly

    logic        accept;
    logic        upper_zero;
    logic        chk_ok;
    logic        start_load;

    // in_ready is decoded from state only, so accept has no path to outputs.
    assign accept     = in_valid && in_ready;
    assign upper_zero = (in_data[7:2] == 6'd0);
    assign chk_ok     = ((run_xor ^ in_data) == 8'd0);
    assign start_load = load && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_nxt = upper_zero ? S_B0 : S_ERR;
            end
            S_B0: begin
                if (accept) state_nxt = S_B1;
            end
            S_B1: begin
                if (accept) state_nxt = S_B2;
            end
            S_B2: begin
                // A malformed B2 aborts before WRITE, so that word is never written.
                if (accept) state_nxt = upper_zero ? S_WRITE : S_ERR;
            end
            S_WRITE: begin
                state_nxt = (word_idx == len_m1) ? S_CHECK : S_B0;
            end
            S_CHECK: begin
                if (accept) state_nxt = chk_ok ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (state only)
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_IDLE:  cpu_hold = 1'b0;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                cpu_hold = 1'b0;
                error    = 1'b1;
            end
            S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CHECK: in_ready = 1'b1;
            S_WRITE: mem_we = 1'b1;
            default: cpu_hold = 1'b1;
        endcase
    end

    assign mem_addr  = word_idx;
    assign mem_wdata = word;

    // -----------------------------------------------------------------------
    // Datapath: length, word index, running XOR, word assembly, start pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_m1    <= '0;
            word_idx  <= '0;
            run_xor   <= '0;
            word      <= '0;
            cpu_start <= 1'b0;
        end else begin
            cpu_start <= 1'b0;
            if (start_load) begin
                word_idx <= '0;
                run_xor  <= '0;
            end
            if (accept && state != S_CHECK) begin
                run_xor <= run_xor ^ in_data;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_m1[7:0]  <= in_data;
                    S_LEN_HI: len_m1[9:8]  <= in_data[1:0];
                    S_B0:     word[7:0]    <= in_data;
                    S_B1:     word[15:8]   <= in_data;
                    S_B2:     word[17:16]  <= in_data[1:0];
                    S_CHECK:  cpu_start    <= chk_ok;
                    default:  ;
                endcase
            end
            // Index 1023 wraps to 0 after the final write; nothing is written past N-1.
            if (state == S_WRITE) begin
                word_idx <= word_idx + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic        cpu_hold;
    logic        cpu_start;
    logic        done;
    logic        error;

    program_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .cpu_start (cpu_start),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] chk;

    // write / start log
    int          wr_cnt = 0;
    int          start_cnt = 0;
    logic [9:0]  log_addr [0:2047];
    logic [17:0] log_data [0:2047];

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (wr_cnt < 2048) begin
                log_addr[wr_cnt] = mem_addr;
                log_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (rst_n && cpu_start) start_cnt = start_cnt + 1;
    end

    task automatic sync;
        @(posedge clk); #1;
    endtask

    task automatic do_load;
        @(negedge clk); load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        chk = 8'h00;
    endtask

    // Offer one byte, wait (bounded) until accepted; returns 1 ns after the accept edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int n;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte_timeout: byte %02h not accepted in_ready=%b required 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk = chk ^ b;
        end
    endtask

    task automatic send_word(input logic [17:0] w, input int max_gap);
        send_byte(w[7:0], max_gap);
        send_byte(w[15:8], max_gap);
        send_byte({6'd0, w[17:16]}, max_gap);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; load = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, error} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b st=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, error);
        end
        rst_n = 1'b1;
        sync;
    endtask

    task automatic test_single_word;
        int w0, s0;
        w0 = wr_cnt; s0 = start_cnt;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b required 0", in_ready); end
        do_load;
        n_cmp++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_bad++; $display("FAIL load_to_ready: got rdy=%b hold=%b required 1 1", in_ready, cpu_hold);
        end
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h02, 0);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 18'h21234) begin
            n_bad++; $display("FAIL single_write: got we=%b addr=%0d data=%h required 1 0 21234", mem_we, mem_addr, mem_wdata);
        end
        send_byte(8'h24, 0);
        @(negedge clk);
        n_cmp++;
        if (cpu_start !== 1'b1 || done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            n_bad++; $display("FAIL single_start: got st=%b done=%b err=%b hold=%b required 1 1 0 0", cpu_start, done, error, cpu_hold);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_start !== 1'b0) begin n_bad++; $display("FAIL single_start_width: got %b required 0", cpu_start); end
        sync;
        n_cmp++;
        if (wr_cnt - w0 != 1 || start_cnt - s0 != 1) begin
            n_bad++; $display("FAIL single_counts: got writes=%0d starts=%0d required 1 1", wr_cnt - w0, start_cnt - s0);
        end
    endtask

    task automatic test_four_words;
        logic [17:0] words [0:3];
        int w0;
        words[0] = 18'h00001; words[1] = 18'h3ABCD; words[2] = 18'h1FFFF; words[3] = 18'h20080;
        do_load;
        w0 = wr_cnt;
        send_byte(8'h03, 3); send_byte(8'h00, 3);
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 3);
            @(negedge clk);
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== words[i] || cpu_hold !== 1'b1) begin
                n_bad++; $display("FAIL four_write%0d: got we=%b addr=%0d data=%h hold=%b required 1 %0d %h 1",
                                  i, mem_we, mem_addr, mem_wdata, cpu_hold, i, words[i]);
            end
        end
        send_byte(chk, 3);
        @(negedge clk);
        n_cmp++;
        if (cpu_start !== 1'b1 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_bad++; $display("FAIL four_start: got st=%b done=%b hold=%b required 1 1 0", cpu_start, done, cpu_hold);
        end
        sync;
        n_cmp++;
        if (wr_cnt - w0 != 4) begin n_bad++; $display("FAIL four_count: got %0d required 4", wr_cnt - w0); end
    endtask

    task automatic test_bad_checksum;
        int w0, s0;
        do_load;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL load_clears_done: got %b required 0", done); end
        w0 = wr_cnt; s0 = start_cnt;
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h02, 0);
        send_byte(8'h25, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_start !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL badchk_state: got err=%b done=%b st=%b hold=%b rdy=%b required 1 0 0 0 0",
                              error, done, cpu_start, cpu_hold, in_ready);
        end
        sync;
        n_cmp++;
        if (wr_cnt - w0 != 1 || start_cnt != s0) begin
            n_bad++; $display("FAIL badchk_counts: got writes=%0d starts=%0d required 1 0", wr_cnt - w0, start_cnt - s0);
        end
        // good frame afterwards clears error
        do_load;
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $display("FAIL load_clears_error: got %b required 0", error); end
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_word(18'h0BEEF, 1);
        send_byte(chk, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_bad++; $display("FAIL recover: got done=%b err=%b required 1 0", done, error);
        end
    endtask

    task automatic test_format_fault;
        int w0;
        do_load;
        w0 = wr_cnt;
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h06, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            n_bad++; $display("FAIL b2_fault: got err=%b we=%b rdy=%b hold=%b required 1 0 0 0", error, mem_we, in_ready, cpu_hold);
        end
        repeat (3) sync;
        n_cmp++;
        if (wr_cnt != w0) begin n_bad++; $display("FAIL b2_fault_nowrite: got %0d writes required 0", wr_cnt - w0); end
        // LEN_HI with nonzero upper bits
        do_load;
        send_byte(8'h00, 0); send_byte(8'h04, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL lenhi_fault: got err=%b rdy=%b required 1 0", error, in_ready);
        end
    endtask

    task automatic test_max_length;
        int w0, bad;
        logic [17:0] w;
        do_load;
        w0 = wr_cnt;
        send_byte(8'hFF, 0); send_byte(8'h03, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 18'(i * 37 + 173077);
            send_word(w, 0);
        end
        send_byte(chk, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cpu_start !== 1'b1) begin
            n_bad++; $display("FAIL max_done: got done=%b st=%b required 1 1", done, cpu_start);
        end
        repeat (3) sync;
        n_cmp++;
        if (wr_cnt - w0 != 1024) begin n_bad++; $display("FAIL max_count: got %0d required 1024", wr_cnt - w0); end
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (w0 + i < 2048) begin
                if (log_addr[w0 + i] !== 10'(i) || log_data[w0 + i] !== 18'(i * 37 + 173077)) bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL max_contents: got %0d bad entries required 0", bad); end
        n_cmp++;
        if (w0 + 1023 < 2048 && log_addr[w0 + 1023] !== 10'd1023) begin
            n_bad++; $display("FAIL max_last_addr: got %0d required 1023", log_addr[w0 + 1023]);
        end
    endtask

    task automatic test_reset_mid_frame;
        do_load;
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        // load while busy (in B0) must be ignored
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        send_word(18'h15A5A, 0);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 18'h15A5A) begin
            n_bad++; $display("FAIL busy_load_ignored: got we=%b addr=%0d data=%h required 1 0 15a5a", mem_we, mem_addr, mem_wdata);
        end
        send_word(18'h2C3C3, 0);
        send_byte(8'h77, 0);          // B0 of word 2; now sitting in B1
        #2;
        n_cmp++;
        if (mem_addr !== 10'd2 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: got addr=%0d rdy=%b hold=%b required 2 1 1", mem_addr, in_ready, cpu_hold);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, error} !== 34'd0) begin
            n_bad++; $display("FAIL async_reset: got rdy=%b we=%b addr=%h wd=%h hold=%b st=%b done=%b err=%b required all 0",
                              in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, done, error);
        end
        @(negedge clk); rst_n = 1'b1;
        sync;
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_four_words;
        test_bad_checksum;
        test_format_fault;
        test_max_length;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills the 18-bit-wide, 1024-deep instruction memory before the core runs. It is the write side of instruction memory: it receives a framed byte stream over a valid/ready handshake and assembles 18-bit instruction words. It writes those words at sequential addresses from 0, verifies an XOR checksum, and then pulses the core's `start`. While loading, it holds the core halted.

## Interface
- No parameters; word width 18, address width 10, and depth 1024 are fixed by the instruction format.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `load` in 1: one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` out 10: write address.
- `mem_wdata` out 18: instruction word to write.
- `cpu_hold` out 1: high while loading; keeps the core from fetching.
- `cpu_start` out 1: one-cycle pulse driving the core's `start` after a good load.
- `done` out 1: level; last load completed with a good checksum.
- `error` out 1: level; last load was aborted by a format or checksum fault.

## Operation
- Frame, in byte order:
  - LEN_LO: (N-1)[7:0].
  - LEN_HI: (N-1)[9:8] in bits [1:0]; bits [7:2] must be 0.
  - N words of three bytes each:
    - B0 = w[7:0].
    - B1 = w[15:8].
    - B2: w[17:16] in bits [1:0]; bits [7:2] must be 0.
  - CHK: XOR of every preceding frame byte.
- N is 1..1024.
- States: IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, CHECK, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR + `load` -> LEN_LO. On this transition, clear `done` and `error`, address counter = 0, running XOR = 0.
  - LEN_LO -> LEN_HI on accept.
  - LEN_HI -> B0 on accept, or ERR if bits [7:2] ≠ 0.
  - B0 -> B1 -> B2 on accept.
  - B2 -> WRITE on accept, or ERR if bits [7:2] ≠ 0.
  - WRITE -> B0 if word index < N-1, else CHECK. The word index increments on WRITE.
  - CHECK -> DONE on accept if (running XOR ^ `in_data`) == 0; otherwise ERR.
- Running XOR includes every accepted byte, LEN_LO through the last B2.
- A byte is accepted on a rising edge with `in_valid` && `in_ready`.
- `in_ready` is high only in LEN_LO, LEN_HI, B0, B1, B2 and CHECK.
- In WRITE:
  - `mem_we` = 1.
  - `mem_addr` = word index.
  - `mem_wdata` = assembled word.
  - `in_ready` = 0.
- Address wraps naturally: index 1023 is the last possible word, and no write ever goes past N-1.
- `cpu_hold` = 1 in every state except IDLE, DONE and ERR.
- ERR does not pulse `cpu_start`. Memory words already written are left as they are.
- `load` while busy (any state other than IDLE/DONE/ERR) is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_hold` = 0, `cpu_start` = 0, `done` = 0, `error` = 0.
  - Internal counters and XOR = 0.
- `load` sampled high -> `in_ready` is high in the next cycle.
- Per word: at least 4 cycles (3 accepts + 1 WRITE). `mem_we` is high in the cycle immediately after the B2 accept edge.
- CHK accepted at edge E -> at E+1, `cpu_start` = 1 for exactly one cycle, `done` = 1, and `cpu_hold` = 0.
- Format or checksum fault at accept edge E -> at E+1, `error` = 1, `cpu_hold` = 0, and `in_ready` = 0.
- `in_valid` low stalls any byte state indefinitely. No timeout.
- Reset asserted mid-frame takes effect immediately. Outputs return to their reset values asynchronously; no partial write is completed.
- All outputs are registered or decoded only from state; there is no combinational path from `in_valid` to any output.

## Test plan
- **Single word.** Send `load`, then 00 00 34 12 02, then CHK = 24. Required: exactly one `mem_we` with `mem_addr` 0 and `mem_wdata` 0x21234, then one `cpu_start` pulse, `done` = 1, `error` = 0.
- **Four words with random `in_valid` gaps.** Required: `mem_we` at addresses 0, 1, 2, 3 in order with matching data, `cpu_hold` high throughout, `cpu_start` one cycle after the CHK accept.
- **Bad checksum.** Same frame as the single-word case but CHK = 25. Required: the word is written, then `error` = 1, no `cpu_start`, `done` = 0. A following good frame then clears `error` and sets `done`.
- **Format fault.** B2 = 0x06. Required: ERR on that accept edge, no `mem_we` for that word, `in_ready` = 0.
- **Maximum length.** N = 1024 (LEN 0xFF, 0x03). Required: 1024 writes at addresses 0..1023, last address 1023, no write after it, then DONE.
- **Reset mid-frame.** Pull `rst_n` low during B1 of word 2. Required: all outputs at reset values immediately. A `load` pulse during an active frame is ignored.
